// File: rtl/boton_eventos.sv
// boton_eventos: turns a debounced button level into short/long/repeat pulses.
// Define BOTON_REPEAT_EN to build the auto-repeat generator in the LONG state.
// Ports:
//   clk           - clock, all logic on posedge
//   reset         - asynchronous active-low reset
//   boton_in      - debounced button level, 1 = pressed
//   pulso_corto   - one-cycle pulse on release of a short press
//   pulso_largo   - one-cycle pulse when the hold reaches COUNT_LARGO
//   pulso_repetir - one-cycle pulse every COUNT_REPETIR cycles of a long hold
//   presionado    - high while a press is in progress (PRESSED or LONG)
module boton_eventos #(
  parameter int COUNT_LARGO   = 50_000_000,
  parameter int COUNT_REPETIR = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_in,
  output logic pulso_corto,
  output logic pulso_largo,
  output logic pulso_repetir,
  output logic presionado
);

  localparam int CMAX = (COUNT_LARGO > COUNT_REPETIR) ?
                        COUNT_LARGO : COUNT_REPETIR;
  localparam int CW = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LARGO_FIN = CW'(COUNT_LARGO - 1);
`ifdef BOTON_REPEAT_EN
  localparam logic [CW-1:0] REP_FIN = CW'(COUNT_REPETIR - 1);
`endif

  typedef enum logic [1:0] {
    BLOQUEO,
    IDLE,
    PRESSED,
    LONG
  } estado_t;

  estado_t       est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          corto_q, corto_d;
  logic          largo_q, largo_d;
  logic          rep_q, rep_d;
  logic          pres_q, pres_d;

  always_comb begin
    est_d   = est_q;
    cnt_d   = cnt_q;
    corto_d = 1'b0;
    largo_d = 1'b0;
    rep_d   = 1'b0;
    unique case (est_q)
      // Held through reset: ignore until a release is seen.
      BLOQUEO: begin
        if (!boton_in) est_d = IDLE;
      end
      IDLE: begin
        if (boton_in) begin
          est_d = PRESSED;
          cnt_d = '0;
        end
      end
      // Release is tested first so it wins on the threshold edge.
      PRESSED: begin
        if (!boton_in) begin
          est_d   = IDLE;
          corto_d = 1'b1;
        end else if (cnt_q == LARGO_FIN) begin
          est_d   = LONG;
          largo_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!boton_in) begin
          est_d = IDLE;
        end
`ifdef BOTON_REPEAT_EN
        else if (cnt_q == REP_FIN) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: est_d = BLOQUEO;
    endcase
    pres_d = (est_d == PRESSED) || (est_d == LONG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est_q   <= BLOQUEO;
      cnt_q   <= '0;
      corto_q <= 1'b0;
      largo_q <= 1'b0;
      rep_q   <= 1'b0;
      pres_q  <= 1'b0;
    end else begin
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      corto_q <= corto_d;
      largo_q <= largo_d;
      rep_q   <= rep_d;
      pres_q  <= pres_d;
    end
  end

  assign pulso_corto   = corto_q;
  assign pulso_largo   = largo_q;
  assign pulso_repetir = rep_q;
  assign presionado    = pres_q;

endmodule

// File: tb/tb_boton_eventos.sv
// tb_boton_eventos: scoreboard bench for boton_eventos.
// Expected outputs are packed {corto, largo, repetir, presionado}.
module tb_boton_eventos;

  localparam int CL = 8;
  localparam int CR = 4;
`ifdef BOTON_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic boton_in = 1'b0;
  logic pulso_corto;
  logic pulso_largo;
  logic pulso_repetir;
  logic presionado;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  boton_eventos #(
    .COUNT_LARGO  (CL),
    .COUNT_REPETIR(CR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .boton_in     (boton_in),
    .pulso_corto  (pulso_corto),
    .pulso_largo  (pulso_largo),
    .pulso_repetir(pulso_repetir),
    .presionado   (presionado)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {pulso_corto, pulso_largo, pulso_repetir, presionado};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (c,l,r,p)", tag, got, exp);
    end
  endtask

  // Drive one sample, push its expectation, compare after the edge.
  task automatic step(input string tag, input logic b,
                      input logic [3:0] e);
    logic [3:0] x;
    @(negedge clk);
    boton_in = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, outs(), 4'bxxxx);
    end else begin
      x = exp_q.pop_front();
      chk(tag, outs(), x);
    end
  endtask

  // Press held on edges 0..n-1, released at edge n, then one idle edge.
  task automatic hold(input string tag, input int n);
    logic [3:0] e;
    for (int k = 0; k <= n; k++) begin
      e[0] = (k < n);
      e[3] = (k == n) && (n <= CL);
      e[2] = (k == CL) && (n > CL);
      e[1] = REP && (k < n) && (k > CL) && (((k - CL) % CR) == 0);
      step($sformatf("%s_e%0d", tag, k), (k < n), e);
    end
    step({tag, "_idle"}, 1'b0, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    boton_in = 1'b0;
    #12;
    chk("rst_outs", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    step("unlock", 1'b0, 4'b0000);

    hold("short3", 3);
    hold("thr8", 8);
    hold("thr9", 9);
    hold("long22", 22);

    // Back-to-back presses: new press accepted right after release.
    step("b2b_0", 1'b1, 4'b0001);
    step("b2b_1", 1'b1, 4'b0001);
    step("b2b_2", 1'b0, 4'b1000);
    step("b2b_3", 1'b1, 4'b0001);
    step("b2b_4", 1'b0, 4'b1000);
    step("b2b_5", 1'b0, 4'b0000);

    // Button held through reset.
    @(negedge clk);
    boton_in = 1'b1;
    reset = 1'b0;
    #2;
    chk("hr_rst", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++)
      step($sformatf("hr_blk%0d", k), 1'b1, 4'b0000);
    step("hr_rel", 1'b0, 4'b0000);
    step("hr_p0", 1'b1, 4'b0001);
    step("hr_p1", 1'b0, 4'b1000);

    // Reset asserted mid long hold, after edge 10.
    for (int k = 0; k <= 10; k++)
      step($sformatf("mh_e%0d", k), 1'b1,
           {1'b0, (k == CL), 1'b0, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    chk("mh_async", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++)
      step($sformatf("mh_blk%0d", k), 1'b1, 4'b0000);
    step("mh_rel", 1'b0, 4'b0000);
    step("mh_p0", 1'b1, 4'b0001);
    step("mh_p1", 1'b0, 4'b1000);
    step("mh_idle", 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boton_eventos.md
# boton_eventos

Button-event classifier that consumes the clean level from the debouncer and turns it into single-cycle action pulses: short press, long press and, optionally, auto-repeat while held. It sits between the debounced button inputs and the game/menu control FSM. The control FSM then reacts to discrete events instead of polling levels or timing holds itself. One instance is used per button.

## Interface
- `COUNT_LARGO`, default 50_000_000: hold duration that classifies a long press, in clk cycles (1 s at 50 MHz). Must be ≥ 2.
- `COUNT_REPETIR`, default 10_000_000: auto-repeat period while long-held, in clk cycles (200 ms). Must be ≥ 2.
- `clk`, input, 1: single clock; all logic on posedge.
- `reset`, input, 1: asynchronous, active-low reset.
- `boton_in`, input, 1: debounced button level, 1 = pressed, synchronous to `clk`.
- `pulso_corto`, output, 1: one-cycle pulse on release of a short press.
- `pulso_largo`, output, 1: one-cycle pulse when the hold reaches the long threshold.
- `pulso_repetir`, output, 1: one-cycle pulse every `COUNT_REPETIR` cycles during a long hold.
- `presionado`, output, 1: level, high while a valid press is in progress (states PRESSED and LONG).

## Operation
- State is encoded as {BLOQUEO, IDLE, PRESSED, LONG}.
- Counter `cnt` is unsigned and wide enough to hold max(`COUNT_LARGO`, `COUNT_REPETIR`)−1. It never wraps.
- All outputs are registered.
- Reset (`reset`=0, asynchronous):
  - state = BLOQUEO, cnt = 0.
  - `pulso_corto` = `pulso_largo` = `pulso_repetir` = `presionado` = 0.
  - Assertion mid-press aborts immediately; no pulse is emitted.
- BLOQUEO: waits for the button to be released, so a button held through reset never produces events.
  - `boton_in`=0 → IDLE.
  - `boton_in`=1 → stay in BLOQUEO.
- IDLE: `boton_in`=1 → PRESSED, cnt = 0.
- PRESSED:
  - `boton_in`=0 → IDLE, `pulso_corto`=1 for one cycle.
  - `boton_in`=1 and cnt == `COUNT_LARGO`−1 → LONG, `pulso_largo`=1 for one cycle, cnt = 0.
  - Otherwise cnt + 1.
- LONG:
  - `boton_in`=0 → IDLE, no pulse.
  - `boton_in`=1 and cnt == `COUNT_REPETIR`−1 → `pulso_repetir`=1 for one cycle (repeat enabled only), cnt = 0.
  - Otherwise cnt + 1.
- Release always has priority over threshold: a release sampled on the threshold edge gives `pulso_corto` (PRESSED) or nothing (LONG).
- At most one pulse output is high in any cycle.
- `presionado` = 1 exactly in the cycles after entering PRESSED or LONG, until the edge that returns to IDLE or reset.

## Timing
- Edge 0 is the first posedge sampling `boton_in`=1 in IDLE; `presionado` rises after edge 0.
- `pulso_largo` is high after edge `COUNT_LARGO`, provided `boton_in`=1 on edges 0..`COUNT_LARGO`.
- `pulso_repetir` is high after edges `COUNT_LARGO` + k·`COUNT_REPETIR`, k ≥ 1, while held.
- `pulso_corto` is high the cycle after the edge that samples `boton_in`=0 in PRESSED. Release-to-event latency is 1 cycle.
- A new press is accepted on the edge immediately after returning to IDLE (no dead time).

## Configuration
- `BOTON_REPEAT_EN` defined: the LONG-state repeat counter and `pulso_repetir` generation are compiled in as above.
- Undefined: `pulso_repetir` is tied to 0 and cnt is not advanced in LONG. LONG simply waits for release; all other behaviour is identical.

## Test plan
Unless noted, use `COUNT_LARGO`=8, `COUNT_REPETIR`=4, `BOTON_REPEAT_EN` defined.
- Short press: `boton_in`=1 on edges 0..2, 0 at edge 3 → `pulso_corto` high only after edge 3; `presionado` high after edges 0..2; no other pulses.
- Threshold boundary: `boton_in`=1 on edges 0..7, 0 at edge 8 → `pulso_corto` after edge 8, no `pulso_largo`. Same with 1 through edge 8 → `pulso_largo` after edge 8, no `pulso_corto`.
- Long hold with repeat: 1 on edges 0..21, 0 at edge 22 →
  - `pulso_largo` after edge 8.
  - `pulso_repetir` after edges 12, 16, 20.
  - `presionado` falls after edge 22; no `pulso_corto`.
- Held through reset: `boton_in`=1 during and 10 cycles after `reset` rises → all outputs 0. Then `boton_in`=0 for one edge and 1 again → normal PRESSED entry and `presionado`=1.
- Reset mid-hold: assert `reset` asynchronously at edge 10 of a long hold → all outputs 0 immediately, without waiting for a clock edge. After release of reset with `boton_in`=1, no events occur until a 0 is sampled.
- Build without `BOTON_REPEAT_EN`, repeat the long-hold scenario → `pulso_largo` after edge 8; `pulso_repetir` never asserts.
